pt8211_sample_fifo: RTL

//  Stereo sample buffer feeding pt8211_drive (idata_left/idata_right, req).

---
 rtl/pt8211_sample_fifo_if.sv | 42 ++++
 rtl/pt8211_sample_fifo.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/pt8211_sample_fifo_if.sv
// -----------------------------------------------------------------------------
// pt8211_sample_fifo_if
//   Bundle between a sample source / pt8211_drive pair (master side) and the
//   stereo sample FIFO (slave side). Everything is synchronous to clk_1p5m_w.
//   Signal groups:
//     push side : wr_en, wr_left, wr_right, full
//     pop side  : req, dout_left, dout_right
//     status    : level, running, overflow, underrun_cnt
// -----------------------------------------------------------------------------
interface pt8211_sample_fifo_if #(
   parameter int DW         = 16,
   parameter int DEPTH_LOG2 = 6
);
   // Push side
   logic                  wr_en;
   logic [DW-1:0]         wr_left;
   logic [DW-1:0]         wr_right;
   logic                  full;

   // Pop side (req comes from pt8211_drive once per frame)
   logic                  req;
   logic [DW-1:0]         dout_left;
   logic [DW-1:0]         dout_right;

   // Status
   logic [DEPTH_LOG2:0]   level;
   logic                  running;
   logic                  overflow;
   logic [15:0]           underrun_cnt;

   // Source plus DAC driver: produce pushes and pop requests, observe the rest.
   modport master (
      output wr_en, wr_left, wr_right, req,
      input  full, dout_left, dout_right, level, running, overflow, underrun_cnt
   );

   // The FIFO itself.
   modport slave (
      input  wr_en, wr_left, wr_right, req,
      output full, dout_left, dout_right, level, running, overflow, underrun_cnt
   );
endinterface

// File: rtl/pt8211_sample_fifo.sv
// -----------------------------------------------------------------------------
// pt8211_sample_fifo
//   Stereo sample buffer between free-running sample sources and the
//   one-request-per-frame pt8211_drive DAC driver.
//
//   - Holds 2**DEPTH_LOG2 {left,right} pairs in a dual-pointer memory.
//   - Starts in PRIMING; playback (RUNNING) begins once the registered fill
//     level reaches PRIME_LEVEL, so a fresh stream has headroom.
//   - A req while RUNNING with an empty buffer is an underrun: it is counted
//     (saturating) and the FIFO falls back to PRIMING to rebuild headroom.
//   - Pops have one cycle of latency; dout_* hold between pops.
//   - A write while full is dropped and sets the sticky overflow flag, unless
//     a pop happens in the same cycle, in which case the write is accepted.
//
//   Build option (macro UNDERRUN_MUTE_EN):
//     defined   : on underrun and on every req seen in PRIMING, dout_* go to 0.
//     undefined : dout_* keep the last popped pair (no click on short gaps).
// -----------------------------------------------------------------------------
module pt8211_sample_fifo #(
   parameter int DW          = 16,
   parameter int DEPTH_LOG2  = 6,
   parameter int PRIME_LEVEL = 32   // 1 .. 2**DEPTH_LOG2
) (
   input  logic                    clk_1p5m_w,
   input  logic                    rst_n,
   pt8211_sample_fifo_if.slave     bus
);

   localparam int DEPTH = 1 << DEPTH_LOG2;
   localparam int LW    = DEPTH_LOG2 + 1;

   localparam logic [LW-1:0] LVL_FULL  = LW'(DEPTH);
   localparam logic [LW-1:0] LVL_PRIME = LW'(PRIME_LEVEL);
   localparam logic [LW-1:0] LVL_ONE   = LW'(1);

`ifdef UNDERRUN_MUTE_EN
   localparam bit MUTE_ON_GAP = 1'b1;
`else
   localparam bit MUTE_ON_GAP = 1'b0;
`endif

   typedef enum logic {
      S_PRIMING = 1'b0,
      S_RUNNING = 1'b1
   } state_t;

   // Storage and state
   logic [2*DW-1:0]        mem [DEPTH];
   logic [DEPTH_LOG2-1:0]  wr_ptr;
   logic [DEPTH_LOG2-1:0]  rd_ptr;
   logic [LW-1:0]          level_q;
   state_t                 state;
   logic [DW-1:0]          dout_left_q;
   logic [DW-1:0]          dout_right_q;
   logic                   overflow_q;
   logic [15:0]            underrun_cnt_q;

   // Per-cycle decisions
   logic                   is_full;
   logic                   is_empty;
   logic                   do_pop;
   logic                   do_underrun;
   logic                   wr_accept;
   logic                   wr_drop;
   logic                   do_silence;

   // Decode what happens at the coming edge from the current registered state.
   always_comb begin
      // NOTE: every signal assigned here gets a default first so no latch is inferred.
      is_full     = 1'b0;
      is_empty    = 1'b0;
      do_pop      = 1'b0;
      do_underrun = 1'b0;
      wr_accept   = 1'b0;
      wr_drop     = 1'b0;
      do_silence  = 1'b0;

      is_full  = (level_q == LVL_FULL);
      is_empty = (level_q == '0);

      if (state == S_RUNNING && bus.req) begin
         do_pop      = !is_empty;
         do_underrun =  is_empty;
      end

      // A pop in the same cycle frees a slot, so a write at full still lands.
      wr_accept = bus.wr_en && (!is_full || do_pop);
      wr_drop   = bus.wr_en && !wr_accept;

      // req while priming is ignored for popping but may still mute the output.
      do_silence = MUTE_ON_GAP &&
                   (do_underrun || (state == S_PRIMING && bus.req));
   end

   // Sample memory: written on every accepted push.
   // NOTE: the storage array has no reset; validity is tracked by level/pointers,
   // which lets it map onto plain RAM.
   always_ff @(posedge clk_1p5m_w) begin
      if (wr_accept) begin
         mem[wr_ptr] <= {bus.wr_left, bus.wr_right};
      end
   end

   // Pointers and fill level.
   // NOTE: sequential state uses non-blocking assignments so every register
   // sees the pre-edge values of the others.
   always_ff @(posedge clk_1p5m_w or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         level_q <= '0;
      end else begin
         if (wr_accept) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)    rd_ptr <= rd_ptr + 1'b1;
         case ({wr_accept, do_pop})
            2'b10:   level_q <= level_q + LVL_ONE;
            2'b01:   level_q <= level_q - LVL_ONE;
            default: level_q <= level_q;
         endcase
      end
   end

   // Playback FSM: prime to PRIME_LEVEL, run until an underrun.
   always_ff @(posedge clk_1p5m_w or negedge rst_n) begin
      if (!rst_n) begin
         state <= S_PRIMING;
      end else begin
         case (state)
            S_PRIMING: if (level_q >= LVL_PRIME) state <= S_RUNNING;
            S_RUNNING: if (do_underrun)          state <= S_PRIMING;
            default:                             state <= S_PRIMING;
         endcase
      end
   end

   // Output sample registers: load on pop, optionally silence on gaps.
   always_ff @(posedge clk_1p5m_w or negedge rst_n) begin
      if (!rst_n) begin
         dout_left_q  <= '0;
         dout_right_q <= '0;
      end else if (do_pop) begin
         {dout_left_q, dout_right_q} <= mem[rd_ptr];
      end else if (do_silence) begin
         dout_left_q  <= '0;
         dout_right_q <= '0;
      end
   end

   // Sticky overflow flag and saturating underrun counter.
   always_ff @(posedge clk_1p5m_w or negedge rst_n) begin
      if (!rst_n) begin
         overflow_q     <= 1'b0;
         underrun_cnt_q <= '0;
      end else begin
         if (wr_drop) overflow_q <= 1'b1;
         if (do_underrun && underrun_cnt_q != 16'hFFFF) begin
            underrun_cnt_q <= underrun_cnt_q + 16'd1;
         end
      end
   end

   assign bus.full         = is_full;
   assign bus.dout_left    = dout_left_q;
   assign bus.dout_right   = dout_right_q;
   assign bus.level        = level_q;
   assign bus.running      = (state == S_RUNNING);
   assign bus.overflow     = overflow_q;
   assign bus.underrun_cnt = underrun_cnt_q;

endmodule
